stream_in_packer: RTL

- Input formatter directly upstream of the cipher core.
- Accepts a 32-bit word stream with valid/ready handshake and packs four words into a 128-bit block tagged with a 2-bit type.
- Routes key blocks to the key-expansion interface; delivers IV/ENC/DEC blocks to the cipher core stream-in interface (vin/tin/din).
- Holds ENC/DEC blocks until the core reports crypto_ready, and flags framing errors.

---
 rtl/stream_in_packer_if.sv | 13 +
 rtl/stream_in_packer.sv | 112 +++++++++++
 2 files changed

// File: rtl/stream_in_packer_if.sv
// Input word stream bundle: 32-bit words tagged with a block type and last flag.
// The packer consumes it as slave; the upstream source (or bench) drives it as master.
// s_ready is owned by the slave side.
interface stream_in_packer_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [1:0]  s_type;
  logic        s_last;

  modport master (output s_valid, output s_data, output s_type, output s_last, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_type, input  s_last, output s_ready);
endinterface

// File: rtl/stream_in_packer.sv
// Packs four 32-bit words into a typed 128-bit block; KEY -> key expansion, IV/ENC/DEC -> core.
// Latency: completing word accepted at edge N gives vout/key_valid during cycle N+1.
// Backpressure: s_ready drops only while an ENC/DEC block waits in HOLD for crypto_ready.
module stream_in_packer #(
  parameter int DROP_CNT_W = 8,
  parameter bit MSW_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  stream_in_packer_if.slave     s,
  input  logic                  crypto_ready,
  output logic                  vout,
  output logic [1:0]            tout,
  output logic [127:0]          dout,
  output logic                  key_valid,
  output logic [127:0]          key_out,
  output logic                  err_frame,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef enum logic {ST_FILL = 1'b0, ST_HOLD = 1'b1} state_t;

  localparam logic [1:0] T_KEY = 2'b10;
  localparam logic [1:0] T_IV  = 2'b11;

  state_t       state_q;
  logic [1:0]   wc_q;
  logic [1:0]   type_q;
  logic [127:0] buf_q;

  logic         accept;
  logic         frame_err;
  logic [6:0]   slot_lsb;
  logic [127:0] blk_d;

  // Ready comes from registered state only, so no path from s_valid.
  assign s.s_ready = (state_q == ST_FILL);

  assign accept = s.s_valid & (state_q == ST_FILL);

  // Slot of the current word: first word at the top when MSW_FIRST, else at the bottom.
  assign slot_lsb = {(MSW_FIRST ? ~wc_q : wc_q), 5'b00000};

  // Framing check and block-with-current-word-inserted view.
  always_comb begin
    frame_err = (s.s_last && (wc_q != 2'd3)) ||
                (!s.s_last && (wc_q == 2'd3)) ||
                ((wc_q != 2'd0) && (s.s_type != type_q));
    blk_d = buf_q;
    blk_d[slot_lsb +: 32] = s.s_data;
  end

  // Fill/hold control with registered outputs, error flag and drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FILL;
      wc_q      <= 2'd0;
      type_q    <= 2'd0;
      buf_q     <= '0;
      vout      <= 1'b0;
      tout      <= 2'd0;
      dout      <= '0;
      key_valid <= 1'b0;
      key_out   <= '0;
      err_frame <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      vout      <= 1'b0;
      key_valid <= 1'b0;
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            if (frame_err) begin
              // Discard partial block including the offending word.
              wc_q      <= 2'd0;
              err_frame <= 1'b1;
              if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end else if (wc_q == 2'd3) begin
              wc_q <= 2'd0;
              if (type_q == T_KEY) begin
                key_out   <= blk_d;
                key_valid <= 1'b1;
              end else if (type_q == T_IV || crypto_ready) begin
                dout <= blk_d;
                tout <= type_q;
                vout <= 1'b1;
              end else begin
                // Core not keyed yet: park the ENC/DEC block.
                buf_q   <= blk_d;
                state_q <= ST_HOLD;
              end
            end else begin
              buf_q <= blk_d;
              wc_q  <= wc_q + 2'd1;
              if (wc_q == 2'd0) type_q <= s.s_type;
            end
          end
        end
        ST_HOLD: begin
          if (crypto_ready) begin
            dout    <= buf_q;
            tout    <= type_q;
            vout    <= 1'b1;
            state_q <= ST_FILL;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

endmodule
